// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle datapath and controller: control-field
// enums, ISA opcodes, instruction field positions and the immediate sign-extender.
package mc_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_NAND  = 3'b010,
    ALU_PASSA = 3'b011
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_ONE  = 2'b01,
    SRCB_IMM6 = 2'b10,
    SRCB_IMM9 = 2'b11
  } srcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_HOLD   = 2'b10,
    PCSRC_HOLD2  = 2'b11
  } pcsrc_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_NDU = 4'b0010,
    OP_LW  = 4'b0100,
    OP_SW  = 4'b0101,
    OP_BEQ = 4'b0110,
    OP_JAL = 4'b0111
  } opcode_e;

  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned RA_MSB   = 11;
  localparam int unsigned RA_LSB   = 9;
  localparam int unsigned RB_MSB   = 8;
  localparam int unsigned RB_LSB   = 6;
  localparam int unsigned RC_MSB   = 5;
  localparam int unsigned RC_LSB   = 3;
  localparam int unsigned CZ_MSB   = 1;
  localparam int unsigned CZ_LSB   = 0;
  localparam int unsigned IMM6_MSB = 5;
  localparam int unsigned IMM9_MSB = 8;

  // Replicate bit msb of the instruction word into every higher bit.
  function automatic logic [15:0] sext(input logic [15:0] v, input int unsigned msb);
    logic [15:0] r;
    r = v;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i > msb) r[i] = v[msb];
    end
    return r;
  endfunction

endpackage

// File: rtl/mc_datapath_if.sv
// Control word, memory bus and status bundle between controller and datapath.
interface mc_datapath_if #(
  parameter int unsigned WIDTH = 16
);
  logic             pcen;
  logic             iord;
  logic             irwrite;
  logic             regwrite;
  logic             regdst;
  logic             memtoreg;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       pcsrc;
  logic [2:0]       alucontrol;
  logic [WIDTH-1:0] readdata;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [3:0]       op;
  logic [1:0]       cz;
  logic             zero;

  modport master (
    output pcen, iord, irwrite, regwrite, regdst, memtoreg, alusrca,
           alusrcb, pcsrc, alucontrol, readdata,
    input  adr, writedata, op, cz, zero
  );

  modport slave (
    input  pcen, iord, irwrite, regwrite, regdst, memtoreg, alusrca,
           alusrcb, pcsrc, alucontrol, readdata,
    output adr, writedata, op, cz, zero
  );
endinterface

// File: rtl/mc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port;
// reset clears every entry and overrides a concurrent write.
module mc_regfile #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] ra1,
  input  logic [$clog2(NREG)-1:0] ra2,
  input  logic [$clog2(NREG)-1:0] wa,
  input  logic [WIDTH-1:0]        wd,
  output logic [WIDTH-1:0]        rd1,
  output logic [WIDTH-1:0]        rd2
);
  logic [WIDTH-1:0] rf [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (we) begin
      rf[wa] <= wd;
    end
  end

  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];
endmodule

// File: rtl/mc_datapath.sv
// Multicycle datapath: PC, IR, A/B, MDR and ALUOut registers, the ALU and its
// operand muxes, executing the control word the controller presents each cycle.
module mc_datapath #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 8
) (
  input  logic         clk,
  input  logic         reset,
  mc_datapath_if.slave bus
);
  import mc_pkg::*;

  localparam int unsigned AW = $clog2(NREG);

  logic [WIDTH-1:0] pc, ir, a, b, mdr, aluout;
  logic [WIDTH-1:0] rd1, rd2, srca, srcb, alu_y, wd;
  logic [AW-1:0]    wa;

  assign wa = bus.regdst ? ir[RC_MSB:RC_LSB] : ir[RA_MSB:RA_LSB];
  assign wd = bus.memtoreg ? mdr : aluout;

  // Port 1 reads rb (into A), port 2 reads ra (into B).
  mc_regfile #(.WIDTH(WIDTH), .NREG(NREG)) u_rf (
    .clk (clk),
    .reset (reset),
    .we  (bus.regwrite),
    .ra1 (ir[RB_MSB:RB_LSB]),
    .ra2 (ir[RA_MSB:RA_LSB]),
    .wa  (wa),
    .wd  (wd),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  always_comb begin
    srca = bus.alusrca ? a : pc;
    case (srcb_e'(bus.alusrcb))
      SRCB_REG:  srcb = b;
      SRCB_ONE:  srcb = {{(WIDTH-1){1'b0}}, 1'b1};
      SRCB_IMM6: srcb = sext(ir, IMM6_MSB);
      SRCB_IMM9: srcb = sext(ir, IMM9_MSB);
      default:   srcb = '0;
    endcase
  end

  always_comb begin
    case (alu_op_e'(bus.alucontrol))
      ALU_ADD:   alu_y = srca + srcb;
      ALU_SUB:   alu_y = srca - srcb;
      ALU_NAND:  alu_y = ~(srca & srcb);
      ALU_PASSA: alu_y = srca;
      default:   alu_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      mdr    <= '0;
      aluout <= '0;
    end else begin
      a      <= rd1;
      b      <= rd2;
      mdr    <= bus.readdata;
      aluout <= alu_y;
      if (bus.irwrite) ir <= bus.readdata;
      if (bus.pcen) begin
        case (pcsrc_e'(bus.pcsrc))
          PCSRC_ALU:    pc <= alu_y;
          PCSRC_ALUOUT: pc <= aluout;
          default:      pc <= pc;
        endcase
      end
    end
  end

  assign bus.adr       = bus.iord ? aluout : pc;
  assign bus.writedata = b;
  assign bus.op        = ir[OP_MSB:OP_LSB];
  assign bus.cz        = ir[CZ_MSB:CZ_LSB];
  assign bus.zero      = (alu_y == '0);
endmodule
